serial_add_sub: RTL and testbench

- Multi-cycle, parametrised two's-complement adder/subtractor.
- Processes WIDTH-bit operands LSB-first, BITS_PER_CYCLE bits per clock, through a ripple chain of full_adder cells with a registered carry between slices.
- Trades latency for area in arithmetic datapaths.
- Start/ready/done handshake, so it can sit behind a simple controller or sequencer.

---
 rtl/serial_add_sub_pkg.sv | 22 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_add_sub.sv | 146 ++++++++++++++
 tb/tb_serial_add_sub.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package serial_add_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of RUN cycles needed to walk the whole operand.
    function automatic int calc_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Step counter width; never narrower than one bit.
    function automatic int calc_cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the slice ripple chain.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: LSB-first, BITS_PER_CYCLE
// bits per clock, carry held in a register between slices.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             carry_in_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o,
    output logic             overflow_o
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = calc_cnt_w(STEPS);

    generate
        if ((WIDTH < 2) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [BPC:0]       chain_c_s;
    logic [BPC-1:0]     slice_sum_s;
    logic [WIDTH-1:0]   slice_ext_s;
    logic [WIDTH-1:0]   res_shift_s;
    logic               last_step_s;

    // Slice ripple chain: low bits of the operand registers plus the held carry.
    assign chain_c_s[0] = carry_q;
    for (genvar i = 0; i < BPC; i++) begin : g_slice
        full_adder u_fa (
            .a_i (a_q[i]),
            .b_i (b_q[i]),
            .c_i (chain_c_s[i]),
            .s_o (slice_sum_s[i]),
            .c_o (chain_c_s[i+1])
        );
    end

    // New slice bits enter the result register from the MSB side.
    assign slice_ext_s = WIDTH'(slice_sum_s);
    assign res_shift_s = (res_q >> BPC) | (slice_ext_s << (WIDTH - BPC));
    assign last_step_s = (cnt_q == CNT_W'(STEPS - 1));

    // Next-state and datapath control for IDLE/RUN/DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    // Subtraction is a + ~b + ~borrow_in.
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    carry_d = sub_i ? ~carry_in_i : carry_in_i;
                    res_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                res_d   = res_shift_s;
                carry_d = chain_c_s[BPC];
                if (last_step_s) begin
                    // Publish only complete results; overflow uses the MSB cell's carries.
                    sum_d   = res_shift_s;
                    cout_d  = chain_c_s[BPC];
                    ovf_d   = chain_c_s[BPC] ^ chain_c_s[BPC-1];
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign sum_o       = sum_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub in three configurations.
module tb_serial_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=8, BPC=1 (main scoreboarded instance)
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       ready8, busy8, done8, cout8, ovf8;
    // WIDTH=8, BPC=4
    logic       start4, sub4, cin4;
    logic [7:0] a4, b4, sum4;
    logic       ready4, busy4, done4, cout4, ovf4;
    // WIDTH=16, BPC=16
    logic        start16, sub16, cin16;
    logic [15:0] a16, b16, sum16;
    logic        ready16, busy16, done16, cout16, ovf16;

    serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub8), .carry_in_i(cin8),
        .a_i(a8), .b_i(b8), .ready_o(ready8), .busy_o(busy8), .done_o(done8),
        .sum_o(sum8), .carry_out_o(cout8), .overflow_o(ovf8));

    serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .sub_i(sub4), .carry_in_i(cin4),
        .a_i(a4), .b_i(b4), .ready_o(ready4), .busy_o(busy4), .done_o(done4),
        .sum_o(sum4), .carry_out_o(cout4), .overflow_o(ovf4));

    serial_add_sub #(.WIDTH(16), .BITS_PER_CYCLE(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .sub_i(sub16), .carry_in_i(cin16),
        .a_i(a16), .b_i(b16), .ready_o(ready16), .busy_o(busy16), .done_o(done16),
        .sum_o(sum16), .carry_out_o(cout16), .overflow_o(ovf16));

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int prev_done = 0;
    int last_done = 0;
    logic [9:0] pub = 10'd0;   // {ovf, cout, sum} last published by u_dut8

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic from integer add/subtract: returns {ovf, cout, sum[15:0]}.
    function automatic logic [17:0] model(input int w, input bit sub, input bit cin,
                                          input int a, input int b);
        int m = 1 << w;
        int h = 1 << (w - 1);
        int sa, sb, r, sr;
        bit co, ov;
        logic [15:0] s;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        if (!sub) begin
            r  = a + b + int'(cin);
            sr = sa + sb + int'(cin);
            co = (r >= m);
        end else begin
            r  = a - b - int'(cin);
            sr = sa - sb - int'(cin);
            co = (r >= 0);
        end
        ov = (sr < -h) || (sr > h - 1);
        s  = 16'(r & (m - 1));
        return {ov, co, s};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on done, otherwise outputs must hold the last result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done8) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sum", {24'd0, sum8}, {24'd0, e.sum});
                check_eq("cout", {31'd0, cout8}, {31'd0, e.cout});
                check_eq("ovf", {31'd0, ovf8}, {31'd0, e.ovf});
                check_eq("latency", cyc, e.due);
                pub       = {e.ovf, e.cout, e.sum};
                prev_done = last_done;
                last_done = cyc;
            end
        end else if (!rst) begin
            check_eq("hold", {22'd0, ovf8, cout8, sum8}, {22'd0, pub});
        end
    end

    task automatic push8(input bit sub, input bit cin, input logic [7:0] a, input logic [7:0] b);
        logic [17:0] m;
        exp_t e;
        m = model(8, sub, cin, int'(a), int'(b));
        e.sum = m[7:0];
        e.cout = m[16];
        e.ovf = m[17];
        e.due = cyc + 8;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            check_eq("timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic issue8(input bit sub, input bit cin, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        sub8 = sub; cin8 = cin; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        push8(sub, cin, a, b);
        start8 = 1'b0;
        wait_drain();
    endtask

    logic [17:0] m;

    initial begin
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = 8'd0; b4 = 8'd0;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'd0, ready8}, 32'd1);
        check_eq("rst_busy", {31'd0, busy8}, 32'd0);
        check_eq("rst_done", {31'd0, done8}, 32'd0);
        check_eq("rst_out", {22'd0, ovf8, cout8, sum8}, 32'd0);
        check_eq("rst_ready4", {31'd0, ready4}, 32'd1);
        check_eq("rst_ready16", {31'd0, ready16}, 32'd1);
        rst = 1'b0;

        // Directed vectors
        issue8(1'b0, 1'b0, 8'h5A, 8'h33);
        issue8(1'b1, 1'b0, 8'h10, 8'h20);
        issue8(1'b1, 1'b0, 8'h80, 8'h01);
        issue8(1'b0, 1'b0, 8'hFF, 8'h01);
        issue8(1'b0, 1'b1, 8'h7F, 8'h00);
        issue8(1'b1, 1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            issue8(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                   8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
        end

        // start held through RUN, second op accepted in DONE
        @(negedge clk);
        sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(posedge clk); #1;
        push8(1'b0, 1'b0, 8'h12, 8'h34);
        sub8 = 1'b1; cin8 = 1'b1; a8 = 8'hC0; b8 = 8'h55;
        @(posedge clk); #1;
        check_eq("run_busy", {31'd0, busy8}, 32'd1);
        check_eq("run_ready", {31'd0, ready8}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        push8(1'b1, 1'b1, 8'hC0, 8'h55);
        start8 = 1'b0;
        wait_drain();
        check_eq("b2b_gap", last_done - prev_done, 32'd9);

        // Reset while the counter sits at step 4
        @(negedge clk);
        sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_ready", {31'd0, ready8}, 32'd1);
        check_eq("abort_busy", {31'd0, busy8}, 32'd0);
        check_eq("abort_done", {31'd0, done8}, 32'd0);
        check_eq("abort_out", {22'd0, ovf8, cout8, sum8}, 32'd0);
        pub = 10'd0;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        issue8(1'b0, 1'b0, 8'h5A, 8'h33);

        // WIDTH=8, BPC=4: two RUN cycles
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sub4 = (k == 1); cin4 = 1'b0;
            a4 = (k == 0) ? 8'h5A : 8'h80;
            b4 = (k == 0) ? 8'h33 : 8'h01;
            start4 = 1'b1;
            m = model(8, sub4, cin4, int'(a4), int'(b4));
            @(posedge clk); #1;
            start4 = 1'b0;
            @(posedge clk); #1;
            check_eq("bpc4_early", {31'd0, done4}, 32'd0);
            @(posedge clk); #1;
            check_eq("bpc4_done", {31'd0, done4}, 32'd1);
            check_eq("bpc4_res", {22'd0, ovf4, cout4, sum4}, {22'd0, m[17], m[16], m[7:0]});
        end

        // WIDTH=16, BPC=16: single RUN cycle
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sub16 = 1'b0; cin16 = 1'b0;
            a16 = (k == 0) ? 16'hFFFF : 16'h7FFF;
            b16 = 16'h0001;
            start16 = 1'b1;
            m = model(16, sub16, cin16, int'(a16), int'(b16));
            @(posedge clk); #1;
            start16 = 1'b0;
            check_eq("w16_busy", {31'd0, busy16}, 32'd1);
            @(posedge clk); #1;
            check_eq("w16_done", {31'd0, done16}, 32'd1);
            check_eq("w16_res", {14'd0, ovf16, cout16, sum16}, {14'd0, m});
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
